// File: rtl/axis_fifo_rd_adapter_pkg.sv
// Shared definitions for the AXI-Stream read adapter of async_fifo_core.
//   DEF_DATA_W : default word width (must match the FIFO core)
//   data_t     : word type at the default width
//   BUF_DEPTH  : entries in the output prefetch buffer
//   pkt_cnt_w  : width of the packet beat counter for a given packet length
package axis_fifo_pkg;

   localparam int unsigned DEF_DATA_W = 8;

   typedef logic [DEF_DATA_W-1:0] data_t;

   localparam int unsigned BUF_DEPTH = 2;

   // At least one bit, so PKT_LEN=1 still gets a legal (constant-zero) counter.
   function automatic int unsigned pkt_cnt_w(input int unsigned pkt_len);
      int unsigned w;
      w = $clog2(pkt_len);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/axis_fifo_rd_adapter_if.sv
// AXI-Stream bundle used by the read adapter.
//   tvalid/tdata/tlast : driven by the master
//   tready             : driven by the slave
interface axis_fifo_rd_adapter_if
   import axis_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
);

   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic              tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/axis_fifo_rd_adapter_out_buf2.sv
// Two-entry output buffer feeding the stream master.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push         : write i_push_data at the tail
//   i_pop          : advance the head (ignored when empty)
//   o_head_data    : registered head entry
//   o_count        : occupancy, 0..2
module axis_out_buf2
   import axis_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_head_data,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] r_mem [BUF_DEPTH];
   logic              r_head;
   logic              r_tail;
   logic [1:0]        r_count;
   logic              w_pop;

   assign w_pop = i_pop & (r_count != 2'd0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_mem   <= '{default: '0};
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_tail] <= i_push_data;
            r_tail        <= ~r_tail;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         // push+pop together leaves the occupancy unchanged
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_data = r_mem[r_head];
   assign o_count     = r_count;

endmodule

// File: rtl/axis_fifo_rd_adapter.sv
// Read-side consumer of async_fifo_core: turns the FIFO ren/rdata/empty port
// into an AXI-Stream master with a 2-entry prefetch buffer.
//   rclk, rrst     : read clock, synchronous active-low reset
//   fifo_ren       : read enable to the FIFO (data returns one cycle later)
//   fifo_rdata     : FIFO read data
//   fifo_empty     : FIFO empty flag
//   m_axis         : stream master (tvalid/tready/tdata/tlast)
//   beat_cnt       : handshaked beats since reset, wrapping
module axis_fifo_rd_adapter
   import axis_fifo_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned PKT_LEN = 16
) (
   input  logic                     rclk,
   input  logic                     rrst,
   output logic                     fifo_ren,
   input  logic [DATA_W-1:0]        fifo_rdata,
   input  logic                     fifo_empty,
   axis_fifo_rd_adapter_if.master   m_axis,
   output logic [15:0]              beat_cnt
);

   logic              r_inflight;
   logic [15:0]       r_beat_cnt;
   logic [1:0]        w_count;
   logic [DATA_W-1:0] w_head;
   logic              w_tvalid;
   logic              w_tlast;
   logic              w_pop;
   logic              w_ren;
   logic [2:0]        w_level;

   assign w_tvalid = (w_count != 2'd0);
   assign w_pop    = w_tvalid & m_axis.tready;

   // Projected occupancy after this edge, counting the word already in flight.
   assign w_level  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_ren    = rrst & ~fifo_empty & (w_level < 3'd2);

   always_ff @(posedge rclk) begin
      if (!rrst) begin
         r_inflight <= 1'b0;
         r_beat_cnt <= '0;
      end else begin
         r_inflight <= w_ren;
         if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
         end
      end
   end

   axis_out_buf2 #(
      .DATA_W (DATA_W)
   ) u_buf (
      .i_clk       (rclk),
      .i_rst_n     (rrst),
      .i_push      (r_inflight),
      .i_push_data (fifo_rdata),
      .i_pop       (w_pop),
      .o_head_data (w_head),
      .o_count     (w_count)
   );

   generate
      if (PKT_LEN == 0) begin : g_no_last
         assign w_tlast = 1'b0;
      end else begin : g_last
         localparam int unsigned PW = pkt_cnt_w(PKT_LEN);
         localparam logic [PW-1:0] LAST = PW'(PKT_LEN - 1);

         logic [PW-1:0] r_pcnt;

         always_ff @(posedge rclk) begin
            if (!rrst) begin
               r_pcnt <= '0;
            end else if (w_pop) begin
               r_pcnt <= (r_pcnt == LAST) ? '0 : r_pcnt + PW'(1);
            end
         end

         assign w_tlast = w_tvalid & (r_pcnt == LAST);
      end
   endgenerate

   assign fifo_ren      = w_ren;
   assign m_axis.tvalid = w_tvalid;
   assign m_axis.tdata  = w_head;
   assign m_axis.tlast  = w_tlast;
   assign beat_cnt      = r_beat_cnt;

endmodule
